// File: rtl/card_dealer.sv
// Deck-draw stage: deals one card per SEND rising edge from a 52-card deck.
// An LFSR picks a start slot; linear probing over an occupancy bitmap avoids repeats.
module card_dealer #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          DECK_SIZE = 52
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       send_i,
   input  logic       shuffle_i,
   output logic       card_valid_o,
   output logic [5:0] card_idx_o,
   output logic [3:0] rank_o,
   output logic [1:0] suit_o,
   output logic [3:0] points_o,
   output logic [5:0] cards_left_o,
   output logic       busy_o,
   output logic       empty_o
);

   typedef enum logic [1:0] {IDLE, PICK, PROBE} state_t;

   state_t                 state_reg, state_next;
   logic [15:0]            lfsr_reg, lfsr_next;
   logic                   send_q_reg;
   logic [5:0]             r_reg, r_next;
   logic [5:0]             idx_reg, idx_next;
   logic [DECK_SIZE-1:0]   dealt_reg, dealt_next;
   logic [5:0]             cards_left_reg, cards_left_next;
   logic                   valid_reg, valid_next;
   logic [5:0]             card_idx_reg;
   logic [3:0]             rank_reg, rank_d;
   logic [1:0]             suit_reg, suit_d;
   logic [3:0]             points_reg, points_d;
   logic [5:0]             suit_base;
   logic                   req;
   logic                   clear_deck;
   logic                   mark;
   logic                   load_card;

   assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
   assign req       = send_i & ~send_q_reg;

   // Per-slot occupancy update: shuffle clears everything, a successful probe sets one bit.
   for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_dealt
      assign dealt_next[gi] = clear_deck ? 1'b0
                            : (dealt_reg[gi] | (mark & (idx_reg == 6'(gi))));
   end

   always_comb begin
      state_next      = state_reg;
      r_next          = r_reg;
      idx_next        = idx_reg;
      cards_left_next = cards_left_reg;
      valid_next      = 1'b0;
      clear_deck      = 1'b0;
      mark            = 1'b0;
      load_card       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (shuffle_i) begin
               clear_deck      = 1'b1;
               cards_left_next = 6'(DECK_SIZE);
            end else if (req && (cards_left_reg != 6'd0)) begin
               r_next     = lfsr_reg[5:0];
               state_next = PICK;
            end
         end
         PICK: begin
            idx_next   = (r_reg >= 6'(DECK_SIZE)) ? (r_reg - 6'(DECK_SIZE)) : r_reg;
            state_next = PROBE;
         end
         PROBE: begin
            if (!dealt_reg[idx_reg]) begin
               mark            = 1'b1;
               load_card       = 1'b1;
               valid_next      = 1'b1;
               cards_left_next = cards_left_reg - 6'd1;
               state_next      = IDLE;
            end else begin
               idx_next = (idx_reg == 6'(DECK_SIZE - 1)) ? 6'd0 : (idx_reg + 6'd1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Card decode from the slot being dealt.
   always_comb begin
      suit_d    = 2'd0;
      suit_base = 6'd0;
      if (idx_reg >= 6'd39) begin
         suit_d    = 2'd3;
         suit_base = 6'd39;
      end else if (idx_reg >= 6'd26) begin
         suit_d    = 2'd2;
         suit_base = 6'd26;
      end else if (idx_reg >= 6'd13) begin
         suit_d    = 2'd1;
         suit_base = 6'd13;
      end
      rank_d   = 4'(idx_reg - suit_base + 6'd1);
      points_d = (rank_d > 4'd10) ? 4'd10 : rank_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_reg      <= IDLE;
         lfsr_reg       <= SEED;
         send_q_reg     <= 1'b0;
         r_reg          <= 6'd0;
         idx_reg        <= 6'd0;
         dealt_reg      <= '0;
         cards_left_reg <= 6'(DECK_SIZE);
         valid_reg      <= 1'b0;
         card_idx_reg   <= 6'd0;
         rank_reg       <= 4'd0;
         suit_reg       <= 2'd0;
         points_reg     <= 4'd0;
      end else begin
         state_reg      <= state_next;
         lfsr_reg       <= lfsr_next;
         send_q_reg     <= send_i;
         r_reg          <= r_next;
         idx_reg        <= idx_next;
         dealt_reg      <= dealt_next;
         cards_left_reg <= cards_left_next;
         valid_reg      <= valid_next;
         if (load_card) begin
            card_idx_reg <= idx_reg;
            rank_reg     <= rank_d;
            suit_reg     <= suit_d;
            points_reg   <= points_d;
         end
      end
   end

   assign card_valid_o = valid_reg;
   assign card_idx_o   = card_idx_reg;
   assign rank_o       = rank_reg;
   assign suit_o       = suit_reg;
   assign points_o     = points_reg;
   assign cards_left_o = cards_left_reg;
   assign busy_o       = (state_reg != IDLE);
   assign empty_o      = (cards_left_reg == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, single deal, level hold, shuffle, full deck,
// collision wrap and reset mid-draw, checked against hand values and a small deck model.
module tb_card_dealer;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       send_i = 1'b0;
   logic       shuffle_i = 1'b0;
   logic       card_valid_o;
   logic [5:0] card_idx_o;
   logic [3:0] rank_o;
   logic [1:0] suit_o;
   logic [3:0] points_o;
   logic [5:0] cards_left_o;
   logic       busy_o;
   logic       empty_o;

   card_dealer #(.SEED(16'hACE1), .DECK_SIZE(52)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .send_i       (send_i),
      .shuffle_i    (shuffle_i),
      .card_valid_o (card_valid_o),
      .card_idx_o   (card_idx_o),
      .rank_o       (rank_o),
      .suit_o       (suit_o),
      .points_o     (points_o),
      .cards_left_o (cards_left_o),
      .busy_o       (busy_o),
      .empty_o      (empty_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Reference LFSR and deck occupancy
   logic [15:0] m_lfsr;
   bit          m_dealt [52];
   int          m_left = 52;

   always @(posedge clk_i) begin
      if (!rst_i) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void predict(input logic [15:0] l, output int idx, output int probes);
      int r;
      r      = int'(l[5:0]);
      idx    = (r >= 52) ? r - 52 : r;
      probes = 0;
      while (m_dealt[idx] && probes < 52) begin
         idx = (idx == 51) ? 0 : idx + 1;
         probes++;
      end
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 52; i++) m_dealt[i] = 1'b0;
      m_left = 52;
   endtask

   // Called at a negedge; raises send_i, waits for the strobe, checks it, then leaves
   // send_i low for one sampled cycle before returning.
   task automatic deal(input string tag, input int shuffle_at, output int lat);
      int  exp_idx, probes, er;
      bit  got;
      predict(m_lfsr, exp_idx, probes);
      send_i = 1'b1;
      lat    = 0;
      got    = 1'b0;
      while (!got && lat < 80) begin
         @(negedge clk_i);
         lat++;
         shuffle_i = (lat == shuffle_at);
         if (card_valid_o) got = 1'b1;
      end
      send_i    = 1'b0;
      shuffle_i = 1'b0;
      er        = exp_idx % 13 + 1;
      chk({tag, " valid"},   32'(got), 1);
      chk({tag, " latency"}, lat, 3 + probes);
      chk({tag, " idx"},     32'(card_idx_o), exp_idx);
      chk({tag, " rank"},    32'(rank_o), er);
      chk({tag, " suit"},    32'(suit_o), exp_idx / 13);
      chk({tag, " points"},  32'(points_o), (er > 10) ? 10 : er);
      m_dealt[exp_idx] = 1'b1;
      m_left--;
      chk({tag, " left"},    32'(cards_left_o), m_left);
      chk({tag, " empty"},   32'(empty_o), (m_left == 0) ? 1 : 0);
      $display("deal %s: idx=%0d rank=%0d suit=%0d pts=%0d lat=%0d left=%0d",
               tag, card_idx_o, rank_o, suit_o, points_o, lat, cards_left_o);
      @(negedge clk_i);
   endtask

   task automatic pulse_shuffle();
      shuffle_i = 1'b1;
      @(negedge clk_i);
      shuffle_i = 1'b0;
      clear_model();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nvalid, nbusy, first_lat, lat, e, p, w;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst valid", 32'(card_valid_o), 0);
      chk("rst idx",   32'(card_idx_o), 0);
      chk("rst rank",  32'(rank_o), 0);
      chk("rst suit",  32'(suit_o), 0);
      chk("rst pts",   32'(points_o), 0);
      chk("rst left",  32'(cards_left_o), 52);
      chk("rst busy",  32'(busy_o), 0);
      chk("rst empty", 32'(empty_o), 0);

      // Single deal from the seed, send_i then held 20 cycles
      send_i = 1'b1;
      rst_i  = 1'b1;
      nvalid = 0;
      first_lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_i);
         if (card_valid_o) begin
            nvalid++;
            if (nvalid == 1) begin
               first_lat = c;
               chk("seed idx",   32'(card_idx_o), 33);
               chk("seed rank",  32'(rank_o), 8);
               chk("seed suit",  32'(suit_o), 2);
               chk("seed pts",   32'(points_o), 8);
               chk("seed left",  32'(cards_left_o), 51);
               chk("seed empty", 32'(empty_o), 0);
            end
         end
      end
      chk("seed latency", first_lat, 3);
      chk("hold strobes", nvalid, 1);
      $display("deal seed: idx=%0d lat=%0d strobes=%0d", card_idx_o, first_lat, nvalid);
      send_i = 1'b0;
      m_dealt[33] = 1'b1;
      m_left = 51;
      @(negedge clk_i);

      // Second rising edge while busy is dropped
      predict(m_lfsr, e, p);
      send_i = 1'b1;
      @(negedge clk_i);
      send_i = 1'b0;
      @(negedge clk_i);
      chk("drop busy", 32'(busy_o), 1);
      send_i = 1'b1;
      nvalid = 0;
      for (int c = 0; c < p + 15; c++) begin
         @(negedge clk_i);
         if (card_valid_o) begin
            nvalid++;
            chk("drop idx", 32'(card_idx_o), e);
         end
      end
      send_i = 1'b0;
      chk("drop strobes", nvalid, 1);
      $display("deal drop: idx=%0d strobes=%0d", card_idx_o, nvalid);
      m_dealt[e] = 1'b1;
      m_left--;
      @(negedge clk_i);

      // Shuffle after 10 deals
      while (m_left > 42) deal("pre", 0, lat);
      pulse_shuffle();
      chk("shuf left",  32'(cards_left_o), 52);
      chk("shuf empty", 32'(empty_o), 0);
      chk("shuf busy",  32'(busy_o), 0);
      $display("shuffle: left=%0d", cards_left_o);

      // Shuffle and request together: shuffle wins
      shuffle_i = 1'b1;
      send_i    = 1'b1;
      @(negedge clk_i);
      shuffle_i = 1'b0;
      nvalid = 0;
      nbusy  = 0;
      repeat (6) begin
         if (card_valid_o) nvalid++;
         if (busy_o) nbusy++;
         @(negedge clk_i);
      end
      send_i = 1'b0;
      chk("shuf+req strobes", nvalid, 0);
      chk("shuf+req busy",    nbusy, 0);
      chk("shuf+req left",    32'(cards_left_o), 52);
      $display("shuffle+request: strobes=%0d left=%0d", nvalid, cards_left_o);
      @(negedge clk_i);

      // Shuffle during PROBE is ignored
      deal("shuf_probe", 2, lat);

      // Full deck
      pulse_shuffle();
      repeat (52) deal("deck", 0, lat);
      chk("deck empty", 32'(empty_o), 1);
      chk("deck left",  32'(cards_left_o), 0);
      send_i = 1'b1;
      nvalid = 0;
      nbusy  = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (card_valid_o) nvalid++;
         if (busy_o) nbusy++;
      end
      send_i = 1'b0;
      chk("53rd strobes", nvalid, 0);
      chk("53rd busy",    nbusy, 0);
      $display("request on empty deck: strobes=%0d busy_cycles=%0d", nvalid, nbusy);
      @(negedge clk_i);

      // Collision wrap: leave only slot 0 free, then start at r = 51
      pulse_shuffle();
      for (int k = 0; k < 51; k++) begin
         w = 0;
         predict(m_lfsr, e, p);
         while (e == 0 && w < 400) begin
            @(negedge clk_i);
            w++;
            predict(m_lfsr, e, p);
         end
         deal("fill", 0, lat);
      end
      w = 0;
      while (m_lfsr[5:0] != 6'd51 && w < 5000) begin
         @(negedge clk_i);
         w++;
      end
      chk("wrap r found", 32'(m_lfsr[5:0]), 51);
      deal("wrap", 0, lat);
      chk("wrap latency", lat, 4);
      chk("wrap idx",     32'(card_idx_o), 0);
      chk("wrap rank",    32'(rank_o), 1);
      chk("wrap pts",     32'(points_o), 1);

      // Reset during PROBE aborts the draw and restores the seed
      pulse_shuffle();
      send_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("abort busy", 32'(busy_o), 1);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("abort valid", 32'(card_valid_o), 0);
      chk("abort left",  32'(cards_left_o), 52);
      chk("abort busy after", 32'(busy_o), 0);
      chk("abort idx",   32'(card_idx_o), 0);
      rst_i = 1'b1;
      clear_model();
      nvalid = 0;
      first_lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk_i);
         if (card_valid_o) begin
            nvalid++;
            if (nvalid == 1) begin
               first_lat = c;
               chk("reseed idx", 32'(card_idx_o), 33);
            end
         end
      end
      send_i = 1'b0;
      chk("reseed latency", first_lat, 3);
      chk("reseed strobes", nvalid, 1);
      $display("reset mid-probe: reseed idx=%0d lat=%0d", card_idx_o, first_lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
